// File: rtl/calc_pkg.sv
// Shared calculator-port types and widths used by the scheduler and its tag pool.
package calc_pkg;
  localparam int CALC_CMD_W    = 4;
  localparam int CALC_DATA_W   = 32;
  localparam int CALC_TAG_W    = 2;
  localparam int CALC_NUM_TAGS = 4;

  typedef enum logic [CALC_CMD_W-1:0] {
    NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, SHL = 4'd5, SHR = 4'd6
  } calc_cmd_e;

  typedef enum logic [1:0] {
    NONE = 2'd0, OK = 2'd1, ERR = 2'd2
  } calc_resp_e;

  // One beat on the DUV input port.
  typedef struct packed {
    logic [CALC_CMD_W-1:0]  cmd;
    logic [CALC_TAG_W-1:0]  tag;
    logic [CALC_DATA_W-1:0] data;
  } calc_port_t;
endpackage

// File: rtl/calc_tag_pool.sv
// Tag busy mask with lowest-free encoder; flags a release of a tag that is not busy.
module calc_tag_pool
  import calc_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alloc,
  input  logic                     rel_valid,
  input  logic [CALC_TAG_W-1:0]    rel_tag,
  output logic [CALC_NUM_TAGS-1:0] busy,
  output logic [CALC_TAG_W-1:0]    free_tag,
  output logic                     any_free,
  output logic                     rel_err
);
  logic [CALC_NUM_TAGS-1:0] alloc_mask, rel_mask;

  always_comb begin
    free_tag = '0;
    for (int i = CALC_NUM_TAGS - 1; i >= 0; i--)
      if (!busy[CALC_TAG_W'(i)]) free_tag = CALC_TAG_W'(i);
  end

  assign any_free   = ~&busy;
  assign rel_err    = rel_valid & ~busy[rel_tag];
  assign alloc_mask = alloc ? (CALC_NUM_TAGS'(1) << free_tag) : '0;
  assign rel_mask   = (rel_valid & busy[rel_tag]) ? (CALC_NUM_TAGS'(1) << rel_tag) : '0;

  // Alloc and release never target the same tag: one is free, the other busy.
  always_ff @(posedge clk or negedge reset)
    if (!reset) busy <= '0;
    else        busy <= (busy & ~rel_mask) | alloc_mask;
endmodule

// File: rtl/calc_port_scheduler.sv
// Arbitrates NUM_REQ requesters onto the two-beat calculator port and tracks tags.
// Build option: CALC_SCHED_FIXED_PRIO_EN selects fixed priority (index 0 highest).
module calc_port_scheduler
  import calc_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0][CALC_CMD_W-1:0]    req_cmd,
  input  logic [NUM_REQ-1:0][CALC_DATA_W-1:0]   req_op1,
  input  logic [NUM_REQ-1:0][CALC_DATA_W-1:0]   req_op2,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic [CALC_CMD_W-1:0]                 req_cmd_out,
  output logic [CALC_DATA_W-1:0]                req_data_out,
  output logic [CALC_TAG_W-1:0]                 req_tag_out,
  input  logic [1:0]                            out_resp,
  input  logic [CALC_TAG_W-1:0]                 out_tag,
  output logic [CALC_NUM_TAGS-1:0]              tags_busy,
  output logic                                  proto_err
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CMD   = 2'd1;
  localparam logic [1:0] ST_DATA2 = 2'd2;

  logic [1:0]             state;
  calc_port_t             port_q;
  logic [CALC_DATA_W-1:0] op2_q;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   gnt_any, grant, cmd_zero, any_free, rel_err;
  logic [CALC_TAG_W-1:0]  free_tag;

`ifdef CALC_SCHED_FIXED_PRIO_EN
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid[IDX_W'(i)]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(i);
      end
  end
`else
  logic [IDX_W-1:0] rr_ptr, rr_j;

  // Descending scan so the candidate closest to rr_ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_j    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      rr_j = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[rr_j]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_j;
      end
    end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset)     rr_ptr <= '0;
    else if (grant) rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
`endif

  assign grant     = reset & gnt_any & any_free & (state != ST_CMD);
  assign req_ready = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign cmd_zero  = (req_cmd[gnt_idx] == CALC_CMD_W'(NOP));

  calc_tag_pool u_tag_pool (
    .clk       (clk),
    .reset     (reset),
    .alloc     (grant & ~cmd_zero),
    .rel_valid (out_resp != 2'(NONE)),
    .rel_tag   (out_tag),
    .busy      (tags_busy),
    .free_tag  (free_tag),
    .any_free  (any_free),
    .rel_err   (rel_err)
  );

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= ST_IDLE;
      port_q    <= '0;
      op2_q     <= '0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= proto_err | rel_err | (grant & cmd_zero);
      if (grant) begin
        state  <= ST_CMD;
        port_q <= '{cmd: req_cmd[gnt_idx], tag: cmd_zero ? '0 : free_tag, data: req_op1[gnt_idx]};
        op2_q  <= req_op2[gnt_idx];
      end else if (state == ST_CMD) begin
        state  <= ST_DATA2;
        port_q <= '{cmd: '0, tag: '0, data: op2_q};
      end else begin
        state  <= ST_IDLE;
        port_q <= '0;
      end
    end

  assign req_cmd_out  = port_q.cmd;
  assign req_tag_out  = port_q.tag;
  assign req_data_out = port_q.data;
endmodule

// File: tb/tb_calc_port_scheduler.sv
// Bench for calc_port_scheduler: directed scenarios plus random traffic against a cycle model.
module tb_calc_port_scheduler;
  import calc_pkg::*;
  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         req_valid;
  logic [N-1:0][3:0]    req_cmd;
  logic [N-1:0][31:0]   req_op1, req_op2;
  logic [N-1:0]         req_ready;
  logic [3:0]           req_cmd_out;
  logic [31:0]          req_data_out;
  logic [1:0]           req_tag_out;
  logic [1:0]           out_resp, out_tag;
  logic [3:0]           tags_busy;
  logic                 proto_err;

  int tests = 0, fails = 0;

  // Model: port word {cmd,tag,data} visible now and the one scheduled next.
  bit [3:0]   m_busy;
  bit         m_err, m_last_gnt;
  int         m_ptr, m_gidx;
  bit [37:0]  m_cur, m_sched;
  bit [N-1:0] m_ready;
  bit [3:0]   legal [4] = '{4'd1, 4'd2, 4'd5, 4'd6};

  calc_port_scheduler #(.NUM_REQ(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_op1(req_op1), .req_op2(req_op2), .req_ready(req_ready),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
    .out_resp(out_resp), .out_tag(out_tag), .tags_busy(tags_busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_busy = '0; m_err = 0; m_last_gnt = 0; m_ptr = 0;
    m_cur = '0; m_sched = '0; m_ready = '0; m_gidx = -1;
  endfunction

  // A command occupies the port for two cycles, so a grant is impossible right after one.
  function automatic void model_pick();
    int j;
    m_gidx = -1;
    if (!m_last_gnt && m_busy != 4'hF)
      for (int k = 0; k < N; k++) begin
`ifdef CALC_SCHED_FIXED_PRIO_EN
        j = k;
`else
        j = (m_ptr + k) % N;
`endif
        if (m_gidx < 0 && req_valid[j]) m_gidx = j;
      end
    m_ready = (m_gidx < 0) ? '0 : (N'(1) << m_gidx);
  endfunction

  function automatic void model_edge();
    bit [37:0] nxt;
    int        t;
    bit        rel_ok;
    nxt = m_sched; m_sched = '0; t = 0;
    rel_ok = (out_resp != 0) && m_busy[out_tag];
    if (out_resp != 0 && !m_busy[out_tag]) m_err = 1;
    if (m_gidx >= 0) begin
      if (req_cmd[m_gidx] == 4'd0) m_err = 1;
      else begin
        while (m_busy[t]) t++;
        m_busy[t] = 1;
      end
      nxt     = {req_cmd[m_gidx], (req_cmd[m_gidx] == 4'd0) ? 2'd0 : 2'(t), req_op1[m_gidx]};
      m_sched = {6'd0, req_op2[m_gidx]};
      m_ptr   = (m_gidx + 1) % N;
    end
    if (rel_ok) m_busy[out_tag] = 0;
    m_cur = nxt;
    m_last_gnt = (m_gidx >= 0);
  endfunction

  // Entered at posedge+1 with inputs settled; samples mid-cycle, then advances the model.
  task automatic step(string nm);
    model_pick();
    #3;
    chk({nm, ".ready"}, req_ready, m_ready);
    chk({nm, ".port"}, {req_cmd_out, req_tag_out, req_data_out}, m_cur);
    chk({nm, ".busy"}, tags_busy, m_busy);
    chk({nm, ".err"}, proto_err, m_err);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 0; req_valid = '0; out_resp = 0; out_tag = 0;
    #1;
    chk("rst.port", {req_cmd_out, req_tag_out, req_data_out}, 38'd0);
    chk("rst.busy", tags_busy, 4'd0);
    chk("rst.err", proto_err, 1'b0);
    @(posedge clk); #1;
    reset = 1;
    model_reset();
  endtask

  task automatic refresh(int pct);
    for (int i = 0; i < N; i++)
      if (!req_valid[i] || m_ready[i]) begin
        if ($urandom_range(0, 99) < pct) begin
          req_valid[i] = 1;
          req_cmd[i]   = legal[$urandom_range(0, 3)];
          req_op1[i]   = $urandom;
          req_op2[i]   = $urandom;
        end else req_valid[i] = 0;
      end
  endtask

  task automatic rand_resp();
    int t;
    out_resp = 0; out_tag = 0;
    if (m_busy != 0 && $urandom_range(0, 3) == 0) begin
      do t = $urandom_range(0, 3); while (!m_busy[t]);
      out_tag  = 2'(t);
      out_resp = 2'($urandom_range(1, 2));
    end
  endtask

  initial begin
    reset = 0; req_valid = '0; req_cmd = '0; req_op1 = '0; req_op2 = '0;
    out_resp = 0; out_tag = 0;
    model_reset();
    @(posedge clk); #1;
    req_valid = 4'b0001;
    #1;
    chk("rst.ready", req_ready, 4'd0);
    do_reset();

    // Single request: ADD 5,3 from req0.
    req_valid = 4'b0001; req_cmd[0] = 4'd1; req_op1[0] = 32'h5; req_op2[0] = 32'h3;
    step("single.t0");
    req_valid = '0;
    step("single.t1");
    chk("single.data2", req_data_out, 32'h3);
    chk("single.busy", tags_busy, 4'b0001);
    step("single.t2");

    // Saturate the tag pool, then release tag 2.
    for (int c = 0; c < 8; c++) begin
      refresh(100);
      step("fill");
    end
    chk("fill.full", tags_busy, 4'hF);
    refresh(100);
    out_resp = 2'd1; out_tag = 2'd2;
    step("rel.same");
    out_resp = 0;
    step("rel.grant");
    chk("rel.tag2", req_tag_out, 2'd2);

    for (int c = 0; c < 400; c++) begin
      refresh(70);
      rand_resp();
      step("rnd");
    end
    out_resp = 0;

    // Reset during the CMD beat; req1 then gets tag 0.
    do_reset();
    req_valid = 4'b0001; req_cmd[0] = 4'd2; req_op1[0] = 32'h11; req_op2[0] = 32'h22;
    step("mid.grant");
    reset = 0;
    req_valid = 4'b0010; req_cmd[1] = 4'd1; req_op1[1] = 32'h7; req_op2[1] = 32'h9;
    #1;
    chk("mid.port", {req_cmd_out, req_tag_out, req_data_out}, 38'd0);
    chk("mid.ready", req_ready, 4'd0);
    chk("mid.busy", tags_busy, 4'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1;
    step("mid.req1");
    req_valid = '0;
    chk("mid.tag0", req_tag_out, 2'd0);
    chk("mid.cmd", req_cmd_out, 4'd1);
    step("mid.cmd1");
    step("mid.data2");

    // A cmd=0 request is issued without a tag and flags an error.
    do_reset();
    req_valid = 4'b0001; req_cmd[0] = 4'd0; req_op1[0] = 32'hA; req_op2[0] = 32'hB;
    step("nop.grant");
    req_valid = '0;
    step("nop.cmd");
    step("nop.data2");
    chk("nop.err", proto_err, 1'b1);
    chk("nop.busy", tags_busy, 4'd0);

    // Response to a free tag: sticky error, mask untouched.
    do_reset();
    req_valid = 4'b0010; req_cmd[1] = 4'd5; req_op1[1] = 32'h1; req_op2[1] = 32'h2;
    step("free.grant");
    req_valid = '0;
    step("free.cmd");
    step("free.data2");
    out_resp = 2'd1; out_tag = 2'd3;
    step("free.resp");
    out_resp = 0;
    step("free.after");
    chk("free.err", proto_err, 1'b1);
    chk("free.busy", tags_busy, 4'b0001);
    step("free.sticky");
    chk("free.err2", proto_err, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/calc_port_scheduler.md
# calc_port_scheduler

Shares one calculator DUV input port between `NUM_REQ` stimulus requesters. Arbitrates round-robin, allocates one of four tags, and sequences the two-cycle command protocol onto the port: cmd, tag and operand 1 in the first cycle, operand 2 in the second. It frees tags when the DUV returns a response. It sits between the stimulus generators and the DUV port, upstream of the command sniffer and golden model.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `clk`  input  1  single clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low (asserted at 0).
- `req_valid`  input  NUM_REQ  per-requester command pending.
- `req_cmd`  input  NUM_REQ×4  per-requester command; 0 is illegal while valid.
- `req_op1`  input  NUM_REQ×32  first operand.
- `req_op2`  input  NUM_REQ×32  second operand.
- `req_ready`  output  NUM_REQ  one-hot grant pulse; the handshake completes when valid & ready.
- `req_cmd_out`  output  4  command to DUV.
- `req_data_out`  output  32  data to DUV.
- `req_tag_out`  output  2  tag to DUV.
- `out_resp`  input  2  DUV response; nonzero means a response is present this cycle.
- `out_tag`  input  2  tag of the response.
- `tags_busy`  output  4  in-use tag mask.
- `proto_err`  output  1  sticky; set by a response to a free tag or a cmd=0 request.

## Operation
- FSM states: IDLE, CMD, DATA2.
  - IDLE → CMD on a grant.
  - CMD → DATA2 unconditionally.
  - DATA2 → CMD on a grant, otherwise → IDLE.
- A grant may only occur in IDLE or DATA2, and only when at least one tag is free.
- Arbitration:
  - Round-robin starting one past the last granted index; the pointer updates only on a grant.
  - `req_ready` is combinational and high only for the granted index.
  - The operands of the granted request are captured at that edge.
- Tag allocation: the lowest-numbered free tag is set busy at the grant edge.
- Tag release: when `out_resp` != 0 and tag `out_tag` is busy, that tag is cleared at the edge.
  - A response to a free tag leaves the mask unchanged and sets `proto_err`.
- Simultaneous release and allocation: allocation uses the pre-edge mask.
  - A freed tag becomes allocatable the following cycle.
  - With all 4 tags busy and a release in the same cycle, no grant occurs that cycle.
- A request with `req_cmd` = 0 is still granted, and is issued as cmd 0 with no tag allocated.
  - It sets `proto_err`.
- Outputs by state:
  - CMD: `req_cmd_out`=cmd, `req_tag_out`=tag, `req_data_out`=op1.
  - DATA2: `req_cmd_out`=0, `req_tag_out`=0, `req_data_out`=op2.
  - IDLE: all zero.

## Timing
- All DUV-side outputs are registered.
- Reset values: `req_cmd_out`, `req_data_out`, `req_tag_out`, `tags_busy`, `proto_err` = 0; FSM = IDLE; RR pointer = 0.
- `req_ready` is 0 while reset is asserted.
- Latency: grant in cycle t → CMD visible in t+1 → operand 2 in t+2.
- Peak throughput is one command per 2 cycles (grant during DATA2).
- Reset mid-operation: outputs are zeroed immediately (asynchronous), all tags are freed, and the in-flight command is dropped.
- After reset deassertion, the first grant can occur in the first clock cycle.

## Configuration
- `CALC_SCHED_FIXED_PRIO_EN`:
  - Defined: fixed priority, with index 0 highest; the RR pointer logic is not compiled.
  - Undefined (default): round-robin as above.

## Structure
- Shared package `calc_pkg`:
  - `calc_cmd_e`: NOP=0, ADD=1, SUB=2, SHL=5, SHR=6.
  - `calc_resp_e`: NONE=0, OK=1, ERR=2.
  - Constants `CALC_CMD_W`=4, `CALC_DATA_W`=32, `CALC_TAG_W`=2, `CALC_NUM_TAGS`=4.
- One sub-module, `calc_tag_pool`: busy mask, lowest-free encoder, alloc/release ports, and the error flag on release of a free tag.

## Test plan
- Single request: req0 ADD, op1=0x5, op2=0x3 → `req_ready[0]` high at t; at t+1 cmd=1, tag=0, data=0x5; at t+2 cmd=0, data=0x3; `tags_busy`=0001.
- All four requesters valid continuously → grants in order 0,1,2,3 every 2 cycles with tags 0,1,2,3; fifth grant stalled until a response; `tags_busy`=1111.
- Tags full, response `out_resp`=1, `out_tag`=2 → no grant in the response cycle; next cycle grant allocates tag 2.
- Response with `out_tag`=3 while tag 3 is free → `proto_err`=1 and stays set; `tags_busy` unchanged.
- Reset driven low during the CMD cycle → outputs 0 within the same cycle; after release, req1 pending is granted and gets tag 0.
- With `CALC_SCHED_FIXED_PRIO_EN` defined, req0 and req2 continuously valid → req0 is granted every opportunity while tags remain; req2 is granted only when req0 drops.
